// File: rtl/axis_frame_sink_if.sv
// AXI-Stream beat bundle between a stream source and axis_frame_sink.
// The master modport drives data, strobes, valid and last, and the slave modport returns ready.
interface axis_frame_sink_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_sink.sv
// axis_frame_sink: captures one tlast-terminated AXI-Stream frame into a
// MEM_SIZE-word buffer. It reports completion, the beat count and sticky
// overflow, and exposes a registered read port into the buffer.
// Optional feature macro: AXIS_SINK_TSTRB_EN. When it is defined, only the
// byte lanes whose tstrb bit is set are written. When it is not defined,
// tstrb is ignored and every lane is written on each accepted beat.
module axis_frame_sink #(
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic                  s00_axis_enable,
    input  logic                  s00_axis_clear,
    axis_frame_sink_if.slave      s00_axis,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int LANES  = DATA_WIDTH / 8;
    localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE_A = ADDR_WIDTH'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    tready_reg, tready_next;
    logic [ADDR_WIDTH-1:0]   word_count_reg, word_count_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    overflow_reg, overflow_next;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    wr_en;
    logic                    mem_we;
    logic [LANES-1:0]        lane_we;
    logic [MEM_AW-1:0]       wr_addr;
    logic [ADDR_WIDTH-1:0]   count_inc;
    logic                    accept;

    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    assign accept    = s00_axis.tvalid & tready_reg;
    assign count_inc = word_count_reg + ADDR_WIDTH'(1);
    assign wr_addr   = word_count_reg[MEM_AW-1:0];
    // A write is never allowed to reach an address at or beyond the buffer depth.
    assign mem_we    = wr_en & (word_count_reg < MEM_SIZE_A);

    // Per-lane write enables: driven by the strobes, or all set.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef AXIS_SINK_TSTRB_EN
        assign lane_we[gi] = s00_axis.tstrb[gi];
`else
        assign lane_we[gi] = 1'b1;
`endif
    end

`ifndef AXIS_SINK_TSTRB_EN
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis.tstrb;
`endif

    // State and registered status outputs. Reset discards any frame in progress.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_reg      <= ST_IDLE;
            tready_reg     <= 1'b0;
            word_count_reg <= '0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tready_reg     <= tready_next;
            word_count_reg <= word_count_next;
            frame_done_reg <= frame_done_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Next-state logic. clear wins over both enable and a simultaneous beat.
    always_comb begin
        state_next      = state_reg;
        tready_next     = tready_reg;
        word_count_next = word_count_reg;
        frame_done_next = frame_done_reg;
        overflow_next   = overflow_reg;
        wr_en           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tready_next = 1'b0;
                if (s00_axis_clear) begin
                    word_count_next = '0;
                    frame_done_next = 1'b0;
                    overflow_next   = 1'b0;
                end else if (s00_axis_enable) begin
                    state_next  = ST_RECEIVE;
                    tready_next = (word_count_reg < MEM_SIZE_A);
                end
            end
            ST_RECEIVE: begin
                if (s00_axis_clear) begin
                    state_next      = ST_IDLE;
                    tready_next     = 1'b0;
                    word_count_next = '0;
                    frame_done_next = 1'b0;
                    overflow_next   = 1'b0;
                end else if (accept) begin
                    wr_en           = 1'b1;
                    word_count_next = count_inc;
                    if (s00_axis.tlast) begin
                        // tlast on the last free slot is still a clean frame.
                        state_next      = ST_DONE;
                        tready_next     = 1'b0;
                        frame_done_next = 1'b1;
                    end else if (count_inc == MEM_SIZE_A) begin
                        state_next    = ST_DONE;
                        tready_next   = 1'b0;
                        overflow_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                tready_next = 1'b0;
                if (s00_axis_clear) begin
                    state_next      = ST_IDLE;
                    word_count_next = '0;
                    frame_done_next = 1'b0;
                    overflow_next   = 1'b0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                tready_next = 1'b0;
            end
        endcase
    end

    // Buffer write. This block has no reset so that it maps onto block RAM.
    always_ff @(posedge s00_axis_aclk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    mem[wr_addr][i*8 +: 8] <= s00_axis.tdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read port. A read of an address being written on the same edge returns the old word.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            rd_data_reg <= '0;
        end else if (rd_addr < MEM_SIZE_A) begin
            rd_data_reg <= mem[rd_addr[MEM_AW-1:0]];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign s00_axis.tready = tready_reg;
    assign rd_data         = rd_data_reg;
    assign word_count      = word_count_reg;
    assign frame_done      = frame_done_reg;
    assign overflow        = overflow_reg;
endmodule

// File: tb/tb_axis_frame_sink.sv
// Testbench for axis_frame_sink. It drives directed frames and then random
// traffic. A frame-level reference model follows the receiver and is compared
// against the DUT outputs on every falling clock edge.
module tb_axis_frame_sink;
    localparam int MEM = 64;
    localparam int AW  = 12;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] word_count;
    logic          frame_done;
    logic          overflow;

    axis_frame_sink_if #(.DATA_WIDTH(DW)) axis ();

    axis_frame_sink #(
        .MEM_SIZE   (MEM),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_enable (enable),
        .s00_axis_clear  (clear),
        .s00_axis        (axis.slave),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .word_count      (word_count),
        .frame_done      (frame_done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: whether a frame is being received, whether a finished frame is held,
    // the beats received so far, the buffer contents, and the expected read result.
    bit          m_rx;
    bit          m_held;
    int          m_count;
    bit          m_done;
    bit          m_ovf;
    logic [31:0] m_mem [MEM];
    bit          m_known [MEM];
    logic [31:0] e_rd;
    bit          e_rd_known;

    logic [31:0] bp_data [8];
    logic [31:0] ovf_data [MEM];
    logic [31:0] ab_data [3];
    logic [31:0] nf_data [2];

    function automatic bit m_ready();
        return m_rx && (m_count < MEM);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rx = 0; m_held = 0; m_count = 0; m_done = 0; m_ovf = 0;
        e_rd = '0; e_rd_known = 1;
    endtask

    // One clock edge of the frame receiver, derived from the inputs present at that edge.
    task automatic model_step();
        int a;
        bit acc;
        a = int'(rd_addr);
        if (a < MEM) begin
            e_rd = m_mem[a];
            e_rd_known = m_known[a];
        end else begin
            e_rd = '0;
            e_rd_known = 1;
        end
        acc = m_ready() && axis.tvalid;
        if (clear) begin
            m_rx = 0; m_held = 0; m_count = 0; m_done = 0; m_ovf = 0;
        end else if (!m_rx && !m_held) begin
            if (enable) m_rx = 1;
        end else if (acc) begin
`ifdef AXIS_SINK_TSTRB_EN
            for (int b = 0; b < 4; b++)
                if (axis.tstrb[b]) m_mem[m_count][b*8 +: 8] = axis.tdata[b*8 +: 8];
            if (axis.tstrb == 4'hF) m_known[m_count] = 1;
`else
            m_mem[m_count] = axis.tdata;
            m_known[m_count] = 1;
`endif
            m_count++;
            if (axis.tlast) begin
                m_rx = 0; m_held = 1; m_done = 1;
            end else if (m_count == MEM) begin
                m_rx = 0; m_held = 1; m_ovf = 1;
            end
            if (m_held)
                $display("frame end: beats=%0d done=%0d overflow=%0d t=%0t", m_count, m_done, m_ovf, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input bit last);
        int n;
        bit rdy;
        n = 0;
        axis.tvalid = 1'b1; axis.tdata = d; axis.tstrb = s; axis.tlast = last;
        do begin
            rdy = m_ready();
            tick();
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL beat_timeout: beat %h never accepted (tready=%b) required accept within 100 cycles", d, axis.tready);
        end
        axis.tvalid = 1'b0; axis.tlast = 1'b0;
    endtask

    task automatic pulse(input bit do_clear, input bit do_enable);
        clear = do_clear; enable = do_enable;
        tick();
        clear = 1'b0; enable = 1'b0;
    endtask

    task automatic read_check(input string name, input int addr, input logic [31:0] exp);
        rd_addr = AW'(addr);
        tick();
        chk(name, rd_data, exp);
    endtask

    // Compare process: checks the DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                chk("tready", 32'(axis.tready), 32'(m_ready()));
                chk("word_count", 32'(word_count), 32'(m_count));
                chk("frame_done", 32'(frame_done), 32'(m_done));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                if (e_rd_known) chk("rd_data", rd_data, e_rd);
            end
        end
    end

    initial begin
        axis.tvalid = 1'b0; axis.tdata = '0; axis.tstrb = 4'hF; axis.tlast = 1'b0;
        for (int i = 0; i < MEM; i++) m_known[i] = 0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tready", 32'(axis.tready), 32'd0);
        chk("reset_word_count", 32'(word_count), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Basic frame of four beats.
        pulse(0, 1);
        chk("basic_tready_armed", 32'(axis.tready), 32'd1);
        send_beat(32'h11111111, 4'hF, 0);
        send_beat(32'h22222222, 4'hF, 0);
        send_beat(32'h33333333, 4'hF, 0);
        send_beat(32'h44444444, 4'hF, 1);
        chk("basic_word_count", 32'(word_count), 32'd4);
        chk("basic_frame_done", 32'(frame_done), 32'd1);
        chk("basic_tready", 32'(axis.tready), 32'd0);
        read_check("basic_rd2", 2, 32'h33333333);
        read_check("rd_out_of_range", 64, 32'h0);

        // Back-pressure: tvalid alternates, eight beats.
        pulse(1, 0);
        pulse(0, 1);
        for (int i = 0; i < 8; i++) bp_data[i] = $urandom;
        for (int i = 0; i < 16; i++) begin
            axis.tvalid = (i % 2 == 0);
            axis.tdata  = (i % 2 == 0) ? bp_data[i/2] : 32'hBAD0BAD0;
            axis.tstrb  = 4'hF;
            axis.tlast  = (i == 14);
            tick();
        end
        axis.tvalid = 1'b0; axis.tlast = 1'b0;
        chk("bp_word_count", 32'(word_count), 32'd8);
        for (int i = 0; i < 8; i++) read_check("bp_mem", i, bp_data[i]);

        // Overflow: 64 beats, none with tlast.
        pulse(1, 0);
        pulse(0, 1);
        for (int i = 0; i < MEM; i++) begin
            ovf_data[i] = $urandom;
            send_beat(ovf_data[i], 4'hF, 0);
        end
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_frame_done", 32'(frame_done), 32'd0);
        chk("ovf_tready", 32'(axis.tready), 32'd0);
        chk("ovf_word_count", 32'(word_count), 32'd64);
        axis.tvalid = 1'b1; axis.tdata = 32'hFEEDFACE;
        tick();
        axis.tvalid = 1'b0;
        chk("ovf_65th_refused", 32'(word_count), 32'd64);
        read_check("ovf_mem63", 63, ovf_data[63]);

        // Abort with clear on the 4th beat, then a fresh two-beat frame.
        pulse(1, 0);
        pulse(0, 1);
        for (int i = 0; i < 3; i++) begin
            ab_data[i] = $urandom;
            send_beat(ab_data[i], 4'hF, 0);
        end
        axis.tvalid = 1'b1; axis.tdata = 32'hDEAD0004; clear = 1'b1;
        tick();
        axis.tvalid = 1'b0; clear = 1'b0;
        chk("abort_word_count", 32'(word_count), 32'd0);
        chk("abort_tready", 32'(axis.tready), 32'd0);
        read_check("abort_mem3_kept", 3, ovf_data[3]);
        pulse(0, 1);
        nf_data[0] = $urandom; nf_data[1] = $urandom;
        send_beat(nf_data[0], 4'hF, 0);
        send_beat(nf_data[1], 4'hF, 1);
        chk("second_word_count", 32'(word_count), 32'd2);
        chk("second_frame_done", 32'(frame_done), 32'd1);
        read_check("second_mem0", 0, nf_data[0]);
        read_check("second_mem1", 1, nf_data[1]);

        // Byte strobes.
        pulse(1, 0);
        pulse(0, 1);
        send_beat(32'hAABBCCDD, 4'hF, 1);
        pulse(1, 0);
        pulse(0, 1);
        send_beat(32'h11223344, 4'h3, 1);
`ifdef AXIS_SINK_TSTRB_EN
        read_check("strobe_mem0", 0, 32'hAABB3344);
`else
        read_check("strobe_mem0", 0, 32'h11223344);
`endif

        // Random traffic.
        pulse(1, 0);
        for (int c = 0; c < 2500; c++) begin
            clear        = m_held ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
            enable       = ($urandom_range(0, 3) == 0);
            axis.tvalid  = ($urandom_range(0, 2) != 0);
            axis.tdata   = $urandom;
            axis.tstrb   = 4'($urandom);
            axis.tlast   = ($urandom_range(0, 63) == 0);
            rd_addr      = AW'($urandom_range(0, 70));
            tick();
        end
        clear = 1'b0; enable = 1'b0; axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tstrb = 4'hF;

        // Asynchronous reset in the middle of a frame.
        pulse(1, 0);
        pulse(0, 1);
        for (int i = 0; i < 5; i++) send_beat($urandom, 4'hF, 0);
        #3 rst = 1'b1;
        #1;
        chk("areset_tready", 32'(axis.tready), 32'd0);
        chk("areset_word_count", 32'(word_count), 32'd0);
        chk("areset_frame_done", 32'(frame_done), 32'd0);
        chk("areset_overflow", 32'(overflow), 32'd0);
        chk("areset_rd_data", rd_data, 32'd0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_tready_idle", 32'(axis.tready), 32'd0);
        pulse(0, 1);
        chk("post_reset_tready_armed", 32'(axis.tready), 32'd1);
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
